// File: rtl/output_port_arbiter.sv
// Per-output-port round-robin arbiter for the 5-port NoC router: picks one requesting
// input, writes its packet into the downstream FIFO and pulses a one-cycle grant back.
module output_port_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_PORTS  = 5,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_PORTS-1:0]            req,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] packet_in,
   input  logic                            downstream_full,
   output logic [NUM_PORTS-1:0]            gnt,
   output logic [DATA_WIDTH-1:0]           packet_out,
   output logic                            wr_en,
   output logic                            busy,
   output logic [CNT_WIDTH-1:0]            pkt_count
);

   localparam int               IDX_W      = 3;
   localparam logic [IDX_W:0]   PORTS_W    = (IDX_W+1)'(NUM_PORTS);
   localparam logic [IDX_W-1:0] LAST_PORT  = IDX_W'(NUM_PORTS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]       winner_q, winner_d;
   logic [NUM_PORTS-1:0]   gnt_q, gnt_d;
   logic [DATA_WIDTH-1:0]  packet_out_q, packet_out_d;
   logic                   wr_en_q, wr_en_d;
   logic [CNT_WIDTH-1:0]   pkt_count_q, pkt_count_d;

   logic [DATA_WIDTH-1:0]  port_pkt [NUM_PORTS];
   logic [IDX_W-1:0]       cand_idx [NUM_PORTS];
   logic [NUM_PORTS-1:0]   cand_req;
   logic                   pick_valid;
   logic [IDX_W-1:0]       pick_idx;

   // (base + off) mod NUM_PORTS for base < NUM_PORTS and off <= NUM_PORTS.
   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] base,
                                                 input logic [IDX_W-1:0] off);
      logic [IDX_W:0] sum;
      sum = {1'b0, base} + {1'b0, off};
      if (sum >= PORTS_W) begin
         sum = sum - PORTS_W;
      end
      return sum[IDX_W-1:0];
   endfunction

   // Candidate gi is the port searched (gi+1)-th after the last winner.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         assign port_pkt[gi] = packet_in[gi*DATA_WIDTH +: DATA_WIDTH];
         assign cand_idx[gi] = wrap_inc(rr_ptr_q, IDX_W'(gi + 1));
         assign cand_req[gi] = req[cand_idx[gi]];
      end
   endgenerate

   always_comb begin
      pick_valid = |cand_req;
      pick_idx   = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         if (cand_req[k]) begin
            pick_idx = cand_idx[k];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      winner_d     = winner_q;
      gnt_d        = '0;
      wr_en_d      = 1'b0;
      packet_out_d = packet_out_q;
      pkt_count_d  = pkt_count_q;

      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               winner_d = pick_idx;
               state_d  = SEND;
            end
         end
         SEND: begin
            // A withdrawn request releases the slot without moving the priority pointer.
            if (!req[winner_q]) begin
               state_d = IDLE;
            end else if (!downstream_full) begin
               packet_out_d = port_pkt[winner_q];
               wr_en_d      = 1'b1;
               gnt_d        = NUM_PORTS'(1) << winner_q;
               rr_ptr_d     = winner_q;
               if (pkt_count_q != '1) begin
                  pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
               end
               state_d = HOLD;
            end
         end
         HOLD: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         rr_ptr_q     <= LAST_PORT;
         winner_q     <= '0;
         gnt_q        <= '0;
         packet_out_q <= '0;
         wr_en_q      <= 1'b0;
         pkt_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         winner_q     <= winner_d;
         gnt_q        <= gnt_d;
         packet_out_q <= packet_out_d;
         wr_en_q      <= wr_en_d;
         pkt_count_q  <= pkt_count_d;
      end
   end

   assign gnt        = gnt_q;
   assign packet_out = packet_out_q;
   assign wr_en      = wr_en_q;
   assign busy       = (state_q != IDLE);
   assign pkt_count  = pkt_count_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench for output_port_arbiter: expected grants are queued as requests are
// raised and checked when the write strobe appears.
module tb_output_port_arbiter;

   localparam int DW = 32;
   localparam int NP = 5;
   localparam int CW = 16;

   logic               clk = 1'b0;
   logic               reset;
   logic [NP-1:0]      req;
   logic [NP*DW-1:0]   packet_in;
   logic               downstream_full;
   logic [NP-1:0]      gnt;
   logic [DW-1:0]      packet_out;
   logic               wr_en;
   logic               busy;
   logic [CW-1:0]      pkt_count;

   logic [DW-1:0]      pkt_data [NP];
   logic [CW-1:0]      exp_count;

   typedef struct {
      logic [NP-1:0] gnt;
      logic [DW-1:0] data;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cycle  = 0;

   assign packet_in = {pkt_data[4], pkt_data[3], pkt_data[2], pkt_data[1], pkt_data[0]};

   always #5 clk = ~clk;

   output_port_arbiter #(
      .DATA_WIDTH (DW),
      .NUM_PORTS  (NP),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .req             (req),
      .packet_in       (packet_in),
      .downstream_full (downstream_full),
      .gnt             (gnt),
      .packet_out      (packet_out),
      .wr_en           (wr_en),
      .busy            (busy),
      .pkt_count       (pkt_count)
   );

   task automatic step();
      @(posedge clk);
      #1;
      cycle++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input int p);
      exp_t e;
      e.gnt  = NP'(1) << p;
      e.data = pkt_data[p];
      sb.push_back(e);
   endtask

   // Waits up to budget edges for a write strobe, then checks it against the queue head.
   task automatic expect_grant(input string tag, input int budget, output int waited);
      exp_t e;
      int   n;
      bit   seen;
      n    = 0;
      seen = 1'b0;
      while (n < budget && !seen) begin
         step();
         n++;
         if (wr_en === 1'b1) seen = 1'b1;
      end
      waited = n;
      chk({tag, "_write_seen"}, 32'(seen), 32'd1);
      if (!seen) begin
         if (sb.size() > 0) e = sb.pop_front();
      end else if (sb.size() == 0) begin
         chk({tag, "_unexpected_write"}, 32'(sb.size()), 32'd1);
      end else begin
         e = sb.pop_front();
         if (exp_count != '1) exp_count = exp_count + CW'(1);
         chk({tag, "_gnt"}, 32'(gnt), 32'(e.gnt));
         chk({tag, "_data"}, packet_out, e.data);
         chk({tag, "_count"}, 32'(pkt_count), 32'(exp_count));
         $display("cycle %0d %s: gnt=%b packet_out=%h pkt_count=%0d waited=%0d",
                  cycle, tag, gnt, packet_out, pkt_count, n);
         req = req & ~gnt;
      end
   endtask

   initial begin
      int n;
      reset           = 1'b0;
      req             = '0;
      downstream_full = 1'b0;
      exp_count       = '0;
      pkt_data[0]     = 32'hA5A5_0001;
      for (int i = 1; i < NP; i++) pkt_data[i] = 32'hC0DE_0000 + 32'(i);

      #1;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_packet_out", packet_out, 32'd0);
      chk("rst_pkt_count", 32'(pkt_count), 32'd0);
      step();
      step();
      reset = 1'b1;
      step();

      // Single request, no backpressure: grant two edges after req is sampled.
      req = 5'b00001;
      push_exp(0);
      step();
      chk("s1_send_busy", 32'(busy), 32'd1);
      chk("s1_send_wr_en", 32'(wr_en), 32'd0);
      expect_grant("s1", 1, n);
      step();
      chk("s1_after_gnt", 32'(gnt), 32'd0);
      chk("s1_after_wr_en", 32'(wr_en), 32'd0);
      chk("s1_after_busy", 32'(busy), 32'd0);
      chk("s1_packet_kept", packet_out, 32'hA5A5_0001);
      chk("s1_count", 32'(pkt_count), 32'd1);

      // All ports requesting from a fresh reset: order 0,1,2,3,4,0, one write per 3 cycles.
      reset = 1'b0;
      exp_count = '0;
      step();
      reset = 1'b1;
      step();
      req = 5'b11111;
      for (int i = 0; i < 6; i++) push_exp(i % NP);
      for (int i = 0; i < 6; i++) begin
         expect_grant("s2_rr", 6, n);
         chk("s2_gap", 32'(n), 32'd2);
         if (i < 5) begin
            step();
            req = req | (NP'(1) << (i % NP));
         end
      end
      req = '0;
      step();
      chk("s2_count", 32'(pkt_count), 32'd6);

      // Port 2 wins, then port 3 must precede port 0.
      req = 5'b00100;
      push_exp(2);
      expect_grant("s3_p2", 6, n);
      req = 5'b01001;
      push_exp(3);
      push_exp(0);
      expect_grant("s3_p3", 6, n);
      expect_grant("s3_p0", 6, n);
      step();

      // Backpressure on winner 1; a later req[4] (ahead of 1 in rr order) must not preempt.
      req = 5'b01000;
      push_exp(3);
      expect_grant("s4_setup", 6, n);
      step();
      downstream_full = 1'b1;
      req = 5'b00010;
      step();
      req = 5'b10010;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("s4_stall_gnt", 32'(gnt), 32'd0);
         chk("s4_stall_wr_en", 32'(wr_en), 32'd0);
         chk("s4_stall_busy", 32'(busy), 32'd1);
      end
      downstream_full = 1'b0;
      push_exp(1);
      push_exp(4);
      expect_grant("s4_p1", 1, n);
      expect_grant("s4_p4", 6, n);
      step();

      // Winner 3 withdraws while stalled: no write, count and priority unchanged.
      downstream_full = 1'b1;
      req = 5'b01000;
      step();
      step();
      chk("s5_stall_busy", 32'(busy), 32'd1);
      chk("s5_stall_wr_en", 32'(wr_en), 32'd0);
      req = '0;
      step();
      chk("s5_idle_busy", 32'(busy), 32'd0);
      chk("s5_idle_wr_en", 32'(wr_en), 32'd0);
      chk("s5_idle_gnt", 32'(gnt), 32'd0);
      chk("s5_count", 32'(pkt_count), 32'(exp_count));
      step();
      chk("s5_no_late_write", 32'(wr_en), 32'd0);
      downstream_full = 1'b0;
      req = 5'b10001;
      push_exp(0);
      push_exp(4);
      expect_grant("s5_p0", 6, n);
      expect_grant("s5_p4", 6, n);
      step();

      // Asynchronous reset in HOLD, between clock edges.
      req = 5'b00100;
      push_exp(2);
      expect_grant("s6_pre", 6, n);
      @(negedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("s6_async_gnt", 32'(gnt), 32'd0);
      chk("s6_async_wr_en", 32'(wr_en), 32'd0);
      chk("s6_async_busy", 32'(busy), 32'd0);
      chk("s6_async_count", 32'(pkt_count), 32'd0);
      chk("s6_async_packet_out", packet_out, 32'd0);
      req = '0;
      exp_count = '0;
      step();
      reset = 1'b1;
      step();
      req = 5'b10000;
      push_exp(4);
      expect_grant("s6_p4", 4, n);
      chk("s6_latency", 32'(n), 32'd2);
      step();

      // Saturation of the forwarded-packet counter.
      force dut.pkt_count_q = 16'hFFFF;
      step();
      release dut.pkt_count_q;
      exp_count = 16'hFFFF;
      chk("s7_preload", 32'(pkt_count), 32'h0000_FFFF);
      req = 5'b00001;
      push_exp(0);
      expect_grant("s7_sat", 4, n);
      step();
      chk("s7_count_hold", 32'(pkt_count), 32'h0000_FFFF);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
